icon_rstage: RTL and testbench



---
 rtl/icon_pkg.sv | 31 +++
 rtl/icon_rnode.sv | 53 +++++
 rtl/icon_rstage.sv | 92 +++++++++
 tb/tb_icon_rstage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/icon_pkg.sv
// Shared interconnect helpers: stage count, split width and lane permutation.
// The forward and return stages both import this so their lane maps always agree.
package icon_pkg;

   function automatic int stage_count(input int inputs);
      return $clog2(inputs);
   endfunction

   function automatic int split_width(input int stage_num, input int inputs);
      return (stage_num < stage_count(inputs) - 1) ? (1 << (stage_num + 1)) : (1 << stage_num);
   endfunction

   // Source lane feeding node-local index k. Inner stages swap lanes across the
   // split boundary (an involution); the last stage interleaves the two halves.
   function automatic int perm(input int k, input int stage_num, input int inputs);
      int split;
      int res;
      split = split_width(stage_num, inputs);
      res   = k;
      if (stage_num < stage_count(inputs) - 1) begin
         if (((k / split) % 2 == 0) && (k % 2 == 1))
            res = k + split - 1;
         else if (((k / split) % 2 == 1) && (k % 2 == 0))
            res = k - split + 1;
      end else begin
         res = (k % 2 == 0) ? (k / 2) : (k / 2 + split);
      end
      return res;
   endfunction

endpackage

// File: rtl/icon_rnode.sv
// 2x2 return node: sel=1 crosses the lanes; 1-cycle latency when PIPELINE=1, else combinational.
// No backpressure; idle lanes drive valid=0 and keep their last data.
module icon_rnode #(
   parameter int PIPELINE = 1,
   parameter int DATA_W   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sel,
   input  logic [1:0]            lane_valid,
   input  logic [1:0][DATA_W-1:0] lane_data,
   output logic [1:0]            node_valid,
   output logic [1:0][DATA_W-1:0] node_data
);

   logic [1:0]             x_valid;
   logic [1:0][DATA_W-1:0] x_data;
   logic [1:0][DATA_W-1:0] data_q;

   always_comb begin
      x_valid = lane_valid;
      x_data  = lane_data;
      if (sel) begin
         x_valid = {lane_valid[0], lane_valid[1]};
         x_data  = {lane_data[0], lane_data[1]};
      end
   end

   // Data only loads on a valid lane so idle outputs keep the last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         for (int j = 0; j < 2; j++)
            if (x_valid[j]) data_q[j] <= x_data[j];
      end
   end

   if (PIPELINE != 0) begin : g_reg
      logic [1:0] valid_q;
      always_ff @(posedge clk) begin
         if (rst) valid_q <= '0;
         else     valid_q <= x_valid;
      end
      assign node_valid = valid_q;
      assign node_data  = data_q;
   end else begin : g_comb
      assign node_valid   = x_valid;
      assign node_data[0] = x_valid[0] ? x_data[0] : data_q[0];
      assign node_data[1] = x_valid[1] ? x_data[1] : data_q[1];
   end

endmodule

// File: rtl/icon_rstage.sv
// Return butterfly stage replaying forward-stage scb vectors from an in-order FIFO; latency PIPELINE cycles.
// No backpressure: overflow drops the push, underflow routes straight through; both set sticky o_err.
module icon_rstage
   import icon_pkg::*;
#(
   parameter int PIPELINE  = 1,
   parameter int STAGE_NUM = 0,
   parameter int INPUTS    = 32,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_push,
   input  logic [INPUTS/2-1:0]           i_scb,
   output logic                          o_full,
   output logic                          o_empty,
   input  logic [INPUTS-1:0]             i_valid,
   input  logic [INPUTS-1:0][DATA_W-1:0] i_data,
   output logic [INPUTS-1:0]             o_valid,
   output logic [INPUTS-1:0][DATA_W-1:0] o_data,
   output logic                          o_err
);

   localparam int NODES = INPUTS / 2;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;

   logic [NODES-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             err_q;
   logic             pop_req;
   logic             pop;
   logic             push;
   logic [NODES-1:0] sel;

   assign o_full  = (count == CW'(DEPTH));
   assign o_empty = (count == '0);
   assign o_err   = err_q;

   // A pop on a full FIFO frees the slot the same-cycle push needs.
   assign pop_req = |i_valid;
   assign pop     = pop_req && !o_empty;
   assign push    = i_push && (!o_full || pop);
   assign sel     = pop ? mem[rd_ptr] : '0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err_q  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if ((i_push && !push) || (pop_req && o_empty))
            err_q <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= i_scb;
   end

   logic [INPUTS-1:0]             r_valid;
   logic [INPUTS-1:0][DATA_W-1:0] r_data;

   for (genvar k = 0; k < INPUTS; k++) begin : g_lane
      localparam int SRC = perm(k, STAGE_NUM, INPUTS);
      assign r_valid[k] = i_valid[SRC];
      assign r_data[k]  = i_data[SRC];
   end

   for (genvar n = 0; n < NODES; n++) begin : g_node
      icon_rnode #(
         .PIPELINE (PIPELINE),
         .DATA_W   (DATA_W)
      ) u_node (
         .clk        (i_clk),
         .rst        (i_rst),
         .sel        (sel[n]),
         .lane_valid (r_valid[2*n+1:2*n]),
         .lane_data  (r_data[2*n+1:2*n]),
         .node_valid (o_valid[2*n+1:2*n]),
         .node_data  (o_data[2*n+1:2*n])
      );
   end

endmodule

// File: tb/tb_icon_rstage.sv
// Directed bench for icon_rstage: 8 lanes, stage 0 and last stage (2), registered outputs.
module tb_icon_rstage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic            push0, push2;
   logic [3:0]      scb0, scb2;
   logic [7:0]      vld0, vld2;
   logic [7:0][31:0] dat0, dat2;
   logic            full0, full2, empty0, empty2, err0, err2;
   logic [7:0]      ov0, ov2;
   logic [7:0][31:0] od0, od2;

   icon_rstage #(.PIPELINE(1), .STAGE_NUM(0), .INPUTS(8), .DATA_W(32), .DEPTH(8)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_push(push0), .i_scb(scb0), .o_full(full0), .o_empty(empty0),
      .i_valid(vld0), .i_data(dat0), .o_valid(ov0), .o_data(od0), .o_err(err0));

   icon_rstage #(.PIPELINE(1), .STAGE_NUM(2), .INPUTS(8), .DATA_W(32), .DEPTH(8)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_push(push2), .i_scb(scb2), .o_full(full2), .o_empty(empty2),
      .i_valid(vld2), .i_data(dat2), .o_valid(ov2), .o_data(od2), .o_err(err2));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Background lane data D0+k, with one chosen lane overridden.
   function automatic logic [7:0][31:0] mk(input int lane, input logic [31:0] d);
      logic [7:0][31:0] v;
      for (int k = 0; k < 8; k++) v[k] = 32'hD0 + k;
      if (lane >= 0) v[lane] = d;
      return v;
   endfunction

   // Stage 0, valid on lanes 2,3,6,7: each node pair lands on its low lane when crossed.
   function automatic logic [7:0] cc_route(input logic [3:0] s);
      return {s[3] ? 2'b01 : 2'b10, s[2] ? 2'b01 : 2'b10,
              s[1] ? 2'b01 : 2'b10, s[0] ? 2'b01 : 2'b10};
   endfunction

   typedef struct {
      logic        push;
      logic [3:0]  scb;
      logic [7:0]  vld;
      int          lane;
      logic [31:0] dat;
      logic [7:0]  ev;
      int          elane;
      logic [31:0] edat;
      logic        ee;
      logic        ef;
      logic        eerr;
   } vec_t;

   vec_t tbl[11];

   task automatic do_reset();
      rst = 1'b1; push0 = 1'b0; vld0 = '0; push2 = 1'b0; vld2 = '0;
      step(); step();
      rst = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 4'h0, 8'h00, -1, 32'h0,  8'h00, -1, 32'h0,  1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 4'h0, 8'h04,  2, 32'hA5, 8'h02,  1, 32'hA5, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 4'h1, 8'h00, -1, 32'h0,  8'h00,  1, 32'hA5, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 4'h0, 8'h04,  2, 32'hA5, 8'h01,  0, 32'hA5, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 4'h2, 8'h00, -1, 32'h0,  8'h00, -1, 32'h0,  1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 4'h3, 8'h00, -1, 32'h0,  8'h00, -1, 32'h0,  1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 4'h4, 8'h08,  3, 32'h22, 8'h04,  2, 32'h22, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 4'h0, 8'h20,  5, 32'h33, 8'h40,  6, 32'h33, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 4'h0, 8'h40,  6, 32'h44, 8'h10,  4, 32'h44, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 4'h0, 8'hFF,  2, 32'h55, 8'hFF,  1, 32'h55, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 4'h0, 8'h00, -1, 32'h0,  8'h00,  1, 32'h55, 1'b1, 1'b0, 1'b1};

      scb0 = '0; scb2 = '0; dat0 = mk(-1, 0); dat2 = mk(-1, 0);
      do_reset();

      chk("rst_valid", {24'h0, ov0}, 32'h0);
      for (int k = 0; k < 8; k++) chk($sformatf("rst_data%0d", k), od0[k], 32'h0);
      chk("rst_empty", {31'h0, empty0}, 32'h1);
      chk("rst_full",  {31'h0, full0},  32'h0);
      chk("rst_err",   {31'h0, err0},   32'h0);

      for (int i = 0; i < 11; i++) begin
         push0 = tbl[i].push; scb0 = tbl[i].scb; vld0 = tbl[i].vld;
         dat0  = mk(tbl[i].lane, tbl[i].dat);
         step();
         chk($sformatf("v%0d_valid", i), {24'h0, ov0}, {24'h0, tbl[i].ev});
         if (tbl[i].elane >= 0)
            chk($sformatf("v%0d_data", i), od0[tbl[i].elane], tbl[i].edat);
         chk($sformatf("v%0d_empty", i), {31'h0, empty0}, {31'h0, tbl[i].ee});
         chk($sformatf("v%0d_full", i),  {31'h0, full0},  {31'h0, tbl[i].ef});
         chk($sformatf("v%0d_err", i),   {31'h0, err0},   {31'h0, tbl[i].eerr});
      end
      push0 = 1'b0; vld0 = '0;

      // Overflow: eight pushes fill, the ninth is dropped and flags an error.
      do_reset();
      for (int j = 1; j <= 8; j++) begin
         push0 = 1'b1; scb0 = 4'(j);
         step();
      end
      chk("ovf_full8", {31'h0, full0}, 32'h1);
      chk("ovf_err8",  {31'h0, err0},  32'h0);
      scb0 = 4'h9;
      step();
      chk("ovf_full9", {31'h0, full0}, 32'h1);
      chk("ovf_err9",  {31'h0, err0},  32'h1);
      push0 = 1'b0;

      for (int j = 1; j <= 8; j++) begin
         logic [3:0] s;
         s = 4'(j);
         vld0 = 8'hCC; dat0 = mk(2, 32'h100 + j);
         step();
         chk($sformatf("rep%0d_valid", j), {24'h0, ov0}, {24'h0, cc_route(s)});
         chk($sformatf("rep%0d_data", j), od0[s[0] ? 0 : 1], 32'h100 + j);
         chk($sformatf("rep%0d_empty", j), {31'h0, empty0}, (j == 8) ? 32'h1 : 32'h0);
         chk($sformatf("rep%0d_full", j),  {31'h0, full0},  32'h0);
      end
      vld0 = '0;

      // Push and pop together at count 2, then reset in the middle of a response.
      push0 = 1'b1; scb0 = 4'h5; step();
      scb0 = 4'h6; step();
      scb0 = 4'h7; vld0 = 8'h04; dat0 = mk(2, 32'h66); step();
      chk("pp_valid", {24'h0, ov0}, 32'h01);
      chk("pp_data",  od0[0], 32'h66);
      chk("pp_empty", {31'h0, empty0}, 32'h0);
      push0 = 1'b0; dat0 = mk(2, 32'h77); step();
      chk("pp2_valid", {24'h0, ov0}, 32'h02);
      chk("pp2_empty", {31'h0, empty0}, 32'h0);
      rst = 1'b1; step();
      chk("mr_valid", {24'h0, ov0}, 32'h0);
      chk("mr_data1", od0[1], 32'h0);
      chk("mr_empty", {31'h0, empty0}, 32'h1);
      chk("mr_err",   {31'h0, err0},   32'h0);
      rst = 1'b0; vld0 = '0;

      // Last stage: halves are interleaved before the nodes.
      push2 = 1'b1; scb2 = 4'h0; step();
      push2 = 1'b0; vld2 = 8'h20; dat2 = mk(5, 32'h3C); step();
      chk("ls_valid", {24'h0, ov2}, 32'h08);
      chk("ls_data",  od2[3], 32'h3C);
      chk("ls_empty", {31'h0, empty2}, 32'h1);
      push2 = 1'b1; scb2 = 4'h2; vld2 = 8'h02; dat2 = mk(1, 32'h77); step();
      chk("ls_uf_valid", {24'h0, ov2}, 32'h04);
      chk("ls_uf_data",  od2[2], 32'h77);
      chk("ls_uf_err",   {31'h0, err2},   32'h1);
      chk("ls_uf_empty", {31'h0, empty2}, 32'h0);
      push2 = 1'b0; dat2 = mk(1, 32'h88); step();
      chk("ls_x_valid", {24'h0, ov2}, 32'h08);
      chk("ls_x_data",  od2[3], 32'h88);
      chk("ls_x_empty", {31'h0, empty2}, 32'h1);
      vld2 = '0; step();
      chk("ls_idle_valid", {24'h0, ov2}, 32'h0);
      chk("ls_idle_data",  od2[3], 32'h88);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
